// File: rtl/or1200_bus_arbiter.sv
// or1200_bus_arbiter: two-master round-robin arbiter sharing one memory port
// between the instruction-fetch (icpu) and data (dcpu) sides of the core.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   icpu_*                fetch request in (cycstb, adr), response out (ack, err, dat)
//   dcpu_*                data request in (cycstb, we, adr, sel, dat), response out
//   mem_*_o               registered shared-port command (cycstb, we, adr, sel, dat)
//   mem_*_i               shared-port response (dat, ack, err)
//   grant_o               one-hot owner: bit0 icpu, bit1 dcpu, 2'b00 idle
//
// Optional feature: define OR1200_BUS_ARBITER_TIMEOUT_EN to enable a bus watchdog.
// A granted cycle that sees no completion for TIMEOUT_CYCLES cycles is terminated
// with a one-cycle err pulse to the owner. Without the macro a grant waits forever
// and TIMEOUT_CYCLES has no effect.

module or1200_bus_arbiter #(
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255,
  parameter int unsigned AW             = 32
) (
  input  logic          clk,
  input  logic          reset,
  // Instruction-fetch requester
  input  logic          icpu_cycstb_i,
  input  logic [AW-1:0] icpu_adr_i,
  output logic          icpu_ack_o,
  output logic          icpu_err_o,
  output logic [31:0]   icpu_dat_o,
  // Data requester
  input  logic          dcpu_cycstb_i,
  input  logic          dcpu_we_i,
  input  logic [AW-1:0] dcpu_adr_i,
  input  logic [3:0]    dcpu_sel_i,
  input  logic [31:0]   dcpu_dat_i,
  output logic          dcpu_ack_o,
  output logic          dcpu_err_o,
  output logic [31:0]   dcpu_dat_o,
  // Shared memory port
  output logic          mem_cycstb_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_adr_o,
  output logic [3:0]    mem_sel_o,
  output logic [31:0]   mem_dat_o,
  input  logic [31:0]   mem_dat_i,
  input  logic          mem_ack_i,
  input  logic          mem_err_i,
  // Current owner
  output logic [1:0]    grant_o
);

  // Encoding doubles as the one-hot grant_o value.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StGntI = 2'b01,
    StGntD = 2'b10
  } state_e;

  state_e          state_q;
  logic            last_q;    // last served: 0 icpu, 1 dcpu
  logic            last_d;
  logic            cycstb_q;
  logic            we_q;
  logic [AW-1:0]   adr_q;
  logic [3:0]      sel_q;
  logic [31:0]     wdat_q;

  logic            granted;
  logic            timeout;
  logic            rsp_err;
  logic            rsp_ack;
  logic            done;
  logic            pick_i;
  logic            pick_d;

  // Tie goes to whoever was not served last.
  assign pick_i = icpu_cycstb_i & (~dcpu_cycstb_i | last_q);
  assign pick_d = dcpu_cycstb_i & (~icpu_cycstb_i | ~last_q);

  assign granted = (state_q != StIdle);
  // Error wins over ack when both arrive; responses in idle are dropped.
  assign rsp_err = granted & (mem_err_i | timeout);
  assign rsp_ack = granted & mem_ack_i & ~rsp_err;
  assign done    = rsp_ack | rsp_err;
  assign last_d  = (state_q == StGntD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      cycstb_q <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      sel_q    <= 4'h0;
      wdat_q   <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_i) begin
            state_q  <= StGntI;
            cycstb_q <= 1'b1;
            we_q     <= 1'b0;
            adr_q    <= icpu_adr_i;
            sel_q    <= 4'hF;
            wdat_q   <= 32'h0;
          end else if (pick_d) begin
            state_q  <= StGntD;
            cycstb_q <= 1'b1;
            we_q     <= dcpu_we_i;
            adr_q    <= dcpu_adr_i;
            sel_q    <= dcpu_sel_i;
            wdat_q   <= dcpu_dat_i;
          end
        end
        // Command registers hold while granted; requester inputs are ignored
        // until the memory cycle completes, even if cycstb drops.
        StGntI, StGntD: begin
          if (done) begin
            state_q  <= StIdle;
            cycstb_q <= 1'b0;
            last_q   <= last_d;
          end
        end
        default: begin
          state_q  <= StIdle;
          cycstb_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef OR1200_BUS_ARBITER_TIMEOUT_EN
  logic [7:0] wdog_q;

  // Idle clears the counter, so every grant starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q <= 8'h0;
    end else if (state_q == StIdle) begin
      wdog_q <= 8'h0;
    end else if (!done) begin
      wdog_q <= wdog_q + 8'd1;
    end
  end

  assign timeout = granted & (wdog_q == TIMEOUT_CYCLES);
`else
  logic unused_timeout_cycles;

  assign timeout               = 1'b0;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  assign grant_o      = state_q;
  assign mem_cycstb_o = cycstb_q;
  assign mem_we_o     = we_q;
  assign mem_adr_o    = adr_q;
  assign mem_sel_o    = sel_q;
  assign mem_dat_o    = wdat_q;

  assign icpu_ack_o = rsp_ack & (state_q == StGntI);
  assign icpu_err_o = rsp_err & (state_q == StGntI);
  assign dcpu_ack_o = rsp_ack & (state_q == StGntD);
  assign dcpu_err_o = rsp_err & (state_q == StGntD);

  // Read data is shared by both requesters while a cycle is open.
  assign icpu_dat_o = granted ? mem_dat_i : 32'h0;
  assign dcpu_dat_o = granted ? mem_dat_i : 32'h0;

endmodule

// File: tb/tb_or1200_bus_arbiter.sv
// Testbench for or1200_bus_arbiter: directed scenarios followed by a randomized
// phase where a driver pushes expected commands/responses into queues and a
// negedge monitor pops and compares them against the DUT.

module tb_or1200_bus_arbiter;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          icpu_cycstb_i;
  logic [AW-1:0] icpu_adr_i;
  logic          icpu_ack_o;
  logic          icpu_err_o;
  logic [31:0]   icpu_dat_o;
  logic          dcpu_cycstb_i;
  logic          dcpu_we_i;
  logic [AW-1:0] dcpu_adr_i;
  logic [3:0]    dcpu_sel_i;
  logic [31:0]   dcpu_dat_i;
  logic          dcpu_ack_o;
  logic          dcpu_err_o;
  logic [31:0]   dcpu_dat_o;
  logic          mem_cycstb_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_adr_o;
  logic [3:0]    mem_sel_o;
  logic [31:0]   mem_dat_o;
  logic [31:0]   mem_dat_i;
  logic          mem_ack_i;
  logic          mem_err_i;
  logic [1:0]    grant_o;

  or1200_bus_arbiter #(
    .TIMEOUT_CYCLES(8'd4),
    .AW            (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .icpu_cycstb_i(icpu_cycstb_i),
    .icpu_adr_i   (icpu_adr_i),
    .icpu_ack_o   (icpu_ack_o),
    .icpu_err_o   (icpu_err_o),
    .icpu_dat_o   (icpu_dat_o),
    .dcpu_cycstb_i(dcpu_cycstb_i),
    .dcpu_we_i    (dcpu_we_i),
    .dcpu_adr_i   (dcpu_adr_i),
    .dcpu_sel_i   (dcpu_sel_i),
    .dcpu_dat_i   (dcpu_dat_i),
    .dcpu_ack_o   (dcpu_ack_o),
    .dcpu_err_o   (dcpu_err_o),
    .dcpu_dat_o   (dcpu_dat_o),
    .mem_cycstb_o (mem_cycstb_o),
    .mem_we_o     (mem_we_o),
    .mem_adr_o    (mem_adr_o),
    .mem_sel_o    (mem_sel_o),
    .mem_dat_o    (mem_dat_o),
    .mem_dat_i    (mem_dat_i),
    .mem_ack_i    (mem_ack_i),
    .mem_err_i    (mem_err_i),
    .grant_o      (grant_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } cmd_t;

  typedef struct {
    int          owner;  // 1 icpu, 2 dcpu
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  cmd_t icmd_q[$];
  cmd_t dcmd_q[$];
  rsp_t rsp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: owner during the current cycle and last served.
  int   m_owner    = 0;
  int   m_last     = 2;
  int   txns       = 0;
  logic rand_phase = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- monitor
  logic [1:0] mon_gexp;
  logic       mon_present;
  logic       mon_done;
  cmd_t       mon_c;
  rsp_t       mon_r;

  always @(negedge clk) begin
    if (rand_phase) begin
      mon_gexp = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
      chk("rnd_grant", grant_o, mon_gexp);
      chk("rnd_cycstb", mem_cycstb_o, (m_owner != 0));
      if (m_owner != 0) begin
        if ((m_owner == 1 && icmd_q.size() == 0) || (m_owner == 2 && dcmd_q.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL rnd_cmd: got a grant to %0d, expected an outstanding request", m_owner);
        end else begin
          mon_c = (m_owner == 1) ? icmd_q[0] : dcmd_q[0];
          chk("rnd_adr", mem_adr_o, mon_c.adr);
          chk("rnd_we", mem_we_o, mon_c.we);
          chk("rnd_sel", mem_sel_o, mon_c.sel);
          chk("rnd_wdat", mem_dat_o, mon_c.dat);
        end
        chk("rnd_idat", icpu_dat_o, mem_dat_i);
        chk("rnd_ddat", dcpu_dat_o, mem_dat_i);
      end
      mon_present = icpu_ack_o | icpu_err_o | dcpu_ack_o | dcpu_err_o;
      mon_done    = 1'b0;
      if (rsp_q.size() == 0) begin
        chk("rnd_no_rsp", mon_present, 1'b0);
      end else begin
        mon_r = rsp_q.pop_front();
        chk("rnd_iack", icpu_ack_o, (mon_r.owner == 1) && mon_r.ack);
        chk("rnd_ierr", icpu_err_o, (mon_r.owner == 1) && mon_r.err);
        chk("rnd_dack", dcpu_ack_o, (mon_r.owner == 2) && mon_r.ack);
        chk("rnd_derr", dcpu_err_o, (mon_r.owner == 2) && mon_r.err);
        chk("rnd_rdat", (mon_r.owner == 1) ? icpu_dat_o : dcpu_dat_o, mon_r.dat);
        mon_done = 1'b1;
        txns++;
        if (mon_r.owner == 1 && icmd_q.size() != 0) void'(icmd_q.pop_front());
        if (mon_r.owner == 2 && dcmd_q.size() != 0) void'(dcmd_q.pop_front());
      end
      // Advance the model: one idle cycle after each completion, round-robin on ties.
      if (m_owner == 0) begin
        if (icpu_cycstb_i && dcpu_cycstb_i) m_owner = (m_last == 2) ? 1 : 2;
        else if (icpu_cycstb_i) m_owner = 1;
        else if (dcpu_cycstb_i) m_owner = 2;
      end else if (mon_done) begin
        m_last  = m_owner;
        m_owner = 0;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  logic [1:0] seq_exp [8];
  int         pulses;
  int         held;
  logic       i_wait    = 1'b0;
  logic       d_wait    = 1'b0;
  logic       rsp_drv   = 1'b0;
  int         rsp_owner = 0;
  logic       delay_set = 1'b0;
  int         delay     = 0;
  int         rtype;
  logic       r_ack;
  logic       r_err;

  initial begin
    reset         = 1'b1;
    icpu_cycstb_i = 1'b0;
    icpu_adr_i    = '0;
    dcpu_cycstb_i = 1'b0;
    dcpu_we_i     = 1'b0;
    dcpu_adr_i    = '0;
    dcpu_sel_i    = 4'h0;
    dcpu_dat_i    = 32'h0;
    mem_dat_i     = 32'h0;
    mem_ack_i     = 1'b0;
    mem_err_i     = 1'b0;
    tick();
    tick();

    // Reset state
    @(negedge clk);
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_cycstb", mem_cycstb_o, 1'b0);
    chk("rst_we", mem_we_o, 1'b0);
    chk("rst_adr", mem_adr_o, 32'h0);
    chk("rst_sel", mem_sel_o, 4'h0);
    chk("rst_wdat", mem_dat_o, 32'h0);
    chk("rst_acks", {icpu_ack_o, icpu_err_o, dcpu_ack_o, dcpu_err_o}, 4'h0);

    // Single fetch, ack two cycles after the strobe
    tick();
    reset         = 1'b0;
    icpu_cycstb_i = 1'b1;
    icpu_adr_i    = 32'h100;
    @(negedge clk);
    chk("fetch_pre_grant", grant_o, 2'b00);
    tick();
    @(negedge clk);
    chk("fetch_grant", grant_o, 2'b01);
    chk("fetch_cycstb", mem_cycstb_o, 1'b1);
    chk("fetch_adr", mem_adr_o, 32'h100);
    chk("fetch_sel", mem_sel_o, 4'hF);
    chk("fetch_we", mem_we_o, 1'b0);
    tick();
    tick();
    mem_ack_i = 1'b1;
    mem_dat_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("fetch_ack", icpu_ack_o, 1'b1);
    chk("fetch_dat", icpu_dat_o, 32'hDEADBEEF);
    chk("fetch_dack", dcpu_ack_o, 1'b0);
    tick();
    mem_ack_i     = 1'b0;
    icpu_cycstb_i = 1'b0;
    @(negedge clk);
    chk("fetch_release", grant_o, 2'b00);
    chk("fetch_cycstb_drop", mem_cycstb_o, 1'b0);

    // Both requesters held after reset: icpu, dcpu alternate with idle gaps
    tick();
    reset = 1'b1;
    tick();
    reset         = 1'b0;
    icpu_cycstb_i = 1'b1;
    dcpu_cycstb_i = 1'b1;
    seq_exp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("rr_seq%0d", i), grant_o, seq_exp[i]);
      tick();
      mem_ack_i = (grant_o != 2'b00);
    end
    icpu_cycstb_i = 1'b0;
    dcpu_cycstb_i = 1'b0;
    mem_ack_i     = 1'b0;
    tick();

    // Data write with ack and err together
    dcpu_cycstb_i = 1'b1;
    dcpu_we_i     = 1'b1;
    dcpu_adr_i    = 32'h2000;
    dcpu_sel_i    = 4'b0011;
    dcpu_dat_i    = 32'h0000ABCD;
    tick();
    mem_ack_i = 1'b1;
    mem_err_i = 1'b1;
    @(negedge clk);
    chk("wr_grant", grant_o, 2'b10);
    chk("wr_we", mem_we_o, 1'b1);
    chk("wr_adr", mem_adr_o, 32'h2000);
    chk("wr_sel", mem_sel_o, 4'b0011);
    chk("wr_wdat", mem_dat_o, 32'h0000ABCD);
    chk("wr_derr", dcpu_err_o, 1'b1);
    chk("wr_dack", dcpu_ack_o, 1'b0);
    chk("wr_iresp", {icpu_ack_o, icpu_err_o}, 2'b00);
    tick();
    mem_ack_i     = 1'b0;
    mem_err_i     = 1'b0;
    dcpu_cycstb_i = 1'b0;
    @(negedge clk);
    chk("wr_release", grant_o, 2'b00);

    // Slave never answers
    tick();
    icpu_cycstb_i = 1'b1;
    icpu_adr_i    = 32'h300;
`ifdef OR1200_BUS_ARBITER_TIMEOUT_EN
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (icpu_err_o) pulses++;
      tick();
      if (pulses != 0) icpu_cycstb_i = 1'b0;
    end
    chk("wdog_pulses", pulses, 1);
    @(negedge clk);
    chk("wdog_release", grant_o, 2'b00);
`else
    held = 0;
    tick();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (grant_o == 2'b01 && mem_cycstb_o) held++;
      tick();
    end
    chk("hang_held", held, 100);
`endif

    // Reset for one cycle in the middle of a data grant
    reset         = 1'b1;
    icpu_cycstb_i = 1'b0;
    tick();
    reset         = 1'b0;
    dcpu_cycstb_i = 1'b1;
    dcpu_we_i     = 1'b1;
    dcpu_adr_i    = 32'h4444;
    dcpu_sel_i    = 4'hC;
    dcpu_dat_i    = 32'h5555;
    tick();
    @(negedge clk);
    chk("mid_grant", grant_o, 2'b10);
    tick();
    reset     = 1'b1;
    mem_dat_i = 32'h12345678;
    tick();
    reset         = 1'b0;
    icpu_cycstb_i = 1'b1;
    @(negedge clk);
    chk("mid_grant0", grant_o, 2'b00);
    chk("mid_cycstb", mem_cycstb_o, 1'b0);
    chk("mid_cmd", {mem_we_o, mem_adr_o, mem_sel_o, mem_dat_o}, 69'h0);
    chk("mid_resp", {icpu_ack_o, icpu_err_o, dcpu_ack_o, dcpu_err_o}, 4'h0);
    chk("mid_dat", {icpu_dat_o, dcpu_dat_o}, 64'h0);
    tick();
    @(negedge clk);
    chk("mid_first_tie", grant_o, 2'b01);

    // Randomized phase
    tick();
    reset         = 1'b1;
    icpu_cycstb_i = 1'b0;
    dcpu_cycstb_i = 1'b0;
    mem_dat_i     = 32'h0;
    tick();
    tick();
    reset      = 1'b0;
    m_owner    = 0;
    m_last     = 2;
    rand_phase = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      mem_ack_i = 1'b0;
      mem_err_i = 1'b0;
      mem_dat_i = $urandom();
      if (rsp_drv) begin
        if (rsp_owner == 1) begin
          i_wait        = 1'b0;
          icpu_cycstb_i = 1'b0;
        end else begin
          d_wait        = 1'b0;
          dcpu_cycstb_i = 1'b0;
        end
        rsp_drv   = 1'b0;
        delay_set = 1'b0;
      end
      if (!i_wait && $urandom_range(3) == 0) begin
        i_wait        = 1'b1;
        icpu_cycstb_i = 1'b1;
        icpu_adr_i    = $urandom();
        icmd_q.push_back('{icpu_adr_i, 1'b0, 4'hF, 32'h0});
      end else if (i_wait && m_owner == 1) begin
        icpu_adr_i = $urandom();
        if ($urandom_range(3) == 0) icpu_cycstb_i = 1'b0;
      end
      if (!d_wait && $urandom_range(3) == 0) begin
        d_wait        = 1'b1;
        dcpu_cycstb_i = 1'b1;
        dcpu_we_i     = 1'($urandom_range(1));
        dcpu_adr_i    = $urandom();
        dcpu_sel_i    = 4'($urandom_range(15));
        dcpu_dat_i    = $urandom();
        dcmd_q.push_back('{dcpu_adr_i, dcpu_we_i, dcpu_sel_i, dcpu_dat_i});
      end else if (d_wait && m_owner == 2) begin
        dcpu_we_i  = 1'($urandom_range(1));
        dcpu_adr_i = $urandom();
        dcpu_sel_i = 4'($urandom_range(15));
        dcpu_dat_i = $urandom();
        if ($urandom_range(3) == 0) dcpu_cycstb_i = 1'b0;
      end
      if (m_owner != 0) begin
        if (!delay_set) begin
          delay     = $urandom_range(3);
          delay_set = 1'b1;
        end
        if (delay == 0) begin
          rtype     = $urandom_range(9);
          r_ack     = (rtype <= 5) || (rtype >= 8);
          r_err     = (rtype >= 6);
          mem_ack_i = r_ack;
          mem_err_i = r_err;
          rsp_q.push_back('{m_owner, r_ack && !r_err, r_err, mem_dat_i});
          rsp_drv   = 1'b1;
          rsp_owner = m_owner;
        end else begin
          delay--;
        end
      end else if ($urandom_range(7) == 0) begin
        // Stray response while idle; must not reach either requester.
        mem_ack_i = 1'($urandom_range(1));
        mem_err_i = 1'($urandom_range(1));
      end
    end
    @(negedge clk);
    #1;
    rand_phase = 1'b0;
    chk("rnd_txn_count", (txns > 200), 1'b1);
    chk("rnd_rsp_drained", rsp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/or1200_bus_arbiter.md
OR1200_BUS_ARBITER -- requirements
Module: or1200_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 8'd255: bus-watchdog limit in cycles, 8-bit.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port icpu_cycstb_i  input  1  instruction-fetch request.
REQ-006 SHALL have port icpu_adr_i  input  AW  fetch address.
REQ-007 SHALL have port icpu_ack_o  output  1  fetch completed.
REQ-008 SHALL have port icpu_err_o  output  1  fetch failed.
REQ-009 SHALL have port icpu_dat_o  output  32  fetch read data.
REQ-010 SHALL have port dcpu_cycstb_i  input  1  data-access request.
REQ-011 SHALL have port dcpu_we_i  input  1  data write enable.
REQ-012 SHALL have port dcpu_adr_i  input  AW  data address.
REQ-013 SHALL have port dcpu_sel_i  input  4  data byte selects.
REQ-014 SHALL have port dcpu_dat_i  input  32  data write data.
REQ-015 SHALL have port dcpu_ack_o / dcpu_err_o  output  1 each  data completed / failed.
REQ-016 SHALL have port dcpu_dat_o  output  32  data read data.
REQ-017 SHALL have port mem_cycstb_o  output  1  shared-port cycle/strobe.
REQ-018 SHALL have port mem_we_o, mem_adr_o, mem_sel_o, mem_dat_o  output  1/AW/4/32  shared-port command.
REQ-019 SHALL have port mem_dat_i  input  32  shared-port read data.
REQ-020 SHALL have port mem_ack_i / mem_err_i  input  1 each  shared-port completion / error.
REQ-021 SHALL have port grant_o  output  2  one-hot owner: bit0 icpu, bit1 dcpu, 2'b00 idle.

Function
REQ-022 SHALL implement FSM IDLE, GNT_I, GNT_D; grant_o reflects state.
REQ-023 In IDLE: one request pending -> grant it next cycle; both pending -> grant the one not served last (round-robin flag last_d); none -> stay IDLE.
REQ-024 On grant, SHALL register requester's adr/we/sel/wdata into mem_*_o and assert mem_cycstb_o from the next cycle (1-cycle request-to-strobe latency); icpu grants drive mem_we_o=0, mem_sel_o=4'hF, mem_dat_o=0.
REQ-025 mem_* command outputs SHALL hold stable while granted, regardless of requester input changes.
REQ-026 While granted, mem_ack_i/mem_err_i/mem_dat_i SHALL route combinationally to the owner only; non-owner ack/err SHALL be 0, both *_dat_o SHALL be mem_dat_i.
REQ-027 mem_ack_i and mem_err_i together -> err reported, ack suppressed.
REQ-028 On completion, mem_cycstb_o SHALL drop next cycle, FSM returns IDLE, last_d updated; one idle cycle minimum between transactions.
REQ-029 Requester dropping cycstb mid-transaction SHALL NOT abort; mem cycle completes and response is still routed.
REQ-030 mem_ack_i/mem_err_i in IDLE SHALL be ignored.

Reset
REQ-031 On reset: state IDLE, last_d=1 (icpu wins first tie), grant_o=0, mem_cycstb_o=0, mem_we_o=0, mem_adr_o=0, mem_sel_o=0, mem_dat_o=0, watchdog=0, all ack/err outputs 0; applies mid-transaction next edge.

Configuration
REQ-032 Macro OR1200_BUS_ARBITER_TIMEOUT_EN defined: 8-bit counter clears on grant, increments each granted cycle without completion; reaching TIMEOUT_CYCLES SHALL pulse owner err_o one cycle, drop mem_cycstb_o next cycle, return IDLE.
REQ-033 Macro undefined: no counter logic; granted state waits indefinitely; TIMEOUT_CYCLES unused.

Verification
REQ-034 icpu req adr=32'h100, mem_ack_i 2 cycles after strobe with dat 32'hDEADBEEF -> mem_adr_o=32'h100, sel 4'hF, icpu_ack_o=1, icpu_dat_o=32'hDEADBEEF, grant_o 01->00.
REQ-035 Both req held after reset -> grant order icpu, dcpu, icpu, dcpu with 1 idle cycle between.
REQ-036 dcpu write adr=32'h2000 sel=4'b0011 dat=32'h0000ABCD, ack+err same cycle -> mem_we_o=1, dcpu_err_o=1, dcpu_ack_o=0.
REQ-037 Macro on, TIMEOUT_CYCLES=4, no mem_ack_i -> owner err_o pulses exactly once, grant_o=00 afterwards; macro off -> grant held 100 cycles.
REQ-038 reset asserted 1 cycle mid GNT_D -> all outputs 0 next cycle; subsequent simultaneous requests grant icpu first.
